// File: rtl/menu_pkg.sv
// Shared key codes, report geometry and report-FSM state encoding for the
// keyboard front end.
package menu_pkg;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_DOWN     = 8'h51;
  localparam logic [7:0] KEY_UP       = 8'h52;
  localparam logic [7:0] KEY_ENTER    = 8'h58;

  localparam int RPT_LEN   = 8;
  localparam int NUM_SLOTS = 6;

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    SCAN,
    UPDATE
  } rpt_state_t;

endpackage

// File: rtl/key_event_gen_if.sv
// Byte-stream handshake carrying HID boot reports from the host into the
// key event generator.
interface key_event_gen_if;

  logic [7:0] rpt_data;
  logic       rpt_valid;
  logic       rpt_ready;

  modport master (
    output rpt_data,
    output rpt_valid,
    input  rpt_ready
  );

  modport slave (
    input  rpt_data,
    input  rpt_valid,
    output rpt_ready
  );

endinterface

// File: rtl/key_fifo.sv
// Small key-event queue; a push into a full queue only lands when a pop
// frees the head slot in the same cycle.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop_ok;
  logic          push_ok;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Turns 8-byte HID boot reports into one-frame key events, with press
// detection against the previous report, auto-repeat and an event FIFO.
module key_event_gen
  import menu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_clk,
  key_event_gen_if.slave rpt,
  output logic [7:0]     keycode,
  output logic           key_valid,
  output logic           overflow
);

  localparam int REP_W = $clog2(REPEAT_DELAY + 1);

  logic [1:0]           sync_reg;
  logic                 sync_prev_reg;
  logic                 frame_tick;

  rpt_state_t           state_reg;
  logic                 rpt_ready_reg;
  logic [2:0]           byte_idx_reg;
  logic [2:0]           scan_idx_reg;
  logic [7:0]           new_slots_reg  [NUM_SLOTS];
  logic [7:0]           prev_slots_reg [NUM_SLOTS];
  logic [7:0]           last_push_reg;

  logic [7:0]           held_key_reg;
  logic [7:0]           held_key_next;
  logic [REP_W-1:0]     rep_cnt_reg;
  logic                 rep_pending_reg;
  logic [7:0]           rep_key_reg;

  logic [NUM_SLOTS-1:0] prev_match;
  logic [NUM_SLOTS-1:0] held_present;
  logic [NUM_SLOTS-1:0] slot_rollover;
  logic [7:0]           scan_key;
  logic                 scan_push;
  logic                 accept;

  logic                 push_req;
  logic [7:0]           push_data;
  logic                 pop;
  logic [7:0]           pop_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic [7:0]           keycode_reg;
  logic                 key_valid_reg;
  logic                 overflow_reg;

  assign keycode       = keycode_reg;
  assign key_valid     = key_valid_reg;
  assign overflow      = overflow_reg;
  assign rpt.rpt_ready = rpt_ready_reg;

  // frame_clk is asynchronous: two flops for metastability, a third for the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], frame_clk};
      sync_prev_reg <= sync_reg[1];
    end
  end

  assign frame_tick = sync_reg[1] && !sync_prev_reg;

  assign accept    = rpt.rpt_valid && rpt_ready_reg;
  assign scan_key  = new_slots_reg[scan_idx_reg];
  assign scan_push = (state_reg == SCAN) && (scan_key != KEY_NONE) && !(|prev_match);

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign prev_match[gi]    = (prev_slots_reg[gi] == scan_key);
    assign held_present[gi]  = (new_slots_reg[gi] == held_key_reg);
    assign slot_rollover[gi] = (new_slots_reg[gi] == KEY_ROLLOVER);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= COLLECT;
      rpt_ready_reg <= 1'b1;
      byte_idx_reg  <= '0;
      scan_idx_reg  <= '0;
      last_push_reg <= KEY_NONE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        new_slots_reg[i]  <= KEY_NONE;
        prev_slots_reg[i] <= KEY_NONE;
      end
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            if (byte_idx_reg >= 3'd2) begin
              new_slots_reg[byte_idx_reg - 3'd2] <= rpt.rpt_data;
            end
            if (byte_idx_reg == 3'(RPT_LEN - 1)) begin
              byte_idx_reg  <= '0;
              state_reg     <= CHECK;
              rpt_ready_reg <= 1'b0;
            end else begin
              byte_idx_reg <= byte_idx_reg + 3'd1;
            end
          end
        end
        CHECK: begin
          // A phantom-key report carries no usable key state at all.
          if (&slot_rollover) begin
            state_reg     <= COLLECT;
            rpt_ready_reg <= 1'b1;
          end else begin
            state_reg     <= SCAN;
            scan_idx_reg  <= '0;
            last_push_reg <= KEY_NONE;
          end
        end
        SCAN: begin
          if (scan_push) begin
            last_push_reg <= scan_key;
          end
          if (scan_idx_reg == 3'(NUM_SLOTS - 1)) begin
            state_reg <= UPDATE;
          end else begin
            scan_idx_reg <= scan_idx_reg + 3'd1;
          end
        end
        UPDATE: begin
          prev_slots_reg <= new_slots_reg;
          state_reg      <= COLLECT;
          rpt_ready_reg  <= 1'b1;
        end
        default: begin
          state_reg     <= COLLECT;
          rpt_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    held_key_next = KEY_NONE;
    if (last_push_reg != KEY_NONE) begin
      held_key_next = last_push_reg;
    end else if (|held_present) begin
      held_key_next = held_key_reg;
    end
  end

  // A fired repeat waits in rep_pending_reg until the scan is not pushing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_key_reg    <= KEY_NONE;
      rep_cnt_reg     <= '0;
      rep_pending_reg <= 1'b0;
      rep_key_reg     <= KEY_NONE;
    end else begin
      if (rep_pending_reg && !scan_push) begin
        rep_pending_reg <= 1'b0;
      end
      if ((state_reg == UPDATE) && (held_key_next != held_key_reg)) begin
        held_key_reg <= held_key_next;
        rep_cnt_reg  <= '0;
      end else if (frame_tick && (held_key_reg != KEY_NONE)) begin
        if (rep_cnt_reg >= REP_W'(REPEAT_DELAY - 1)) begin
          rep_cnt_reg     <= REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
          rep_pending_reg <= 1'b1;
          rep_key_reg     <= held_key_reg;
        end else begin
          rep_cnt_reg <= rep_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign push_req  = scan_push || rep_pending_reg;
  assign push_data = scan_push ? scan_key : rep_key_reg;
  assign pop       = frame_tick && !fifo_empty;

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode_reg   <= KEY_NONE;
      key_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (frame_tick) begin
        keycode_reg   <= fifo_empty ? KEY_NONE : pop_data;
        key_valid_reg <= !fifo_empty;
      end
      if (push_req && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed and randomized report/frame sequences for key_event_gen, checked
// against a queue-based model of the event rules.
module tb_key_event_gen;

  localparam int DEPTH  = 4;
  localparam int DELAY  = 30;
  localparam int PERIOD = 6;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       key_valid;
  logic       overflow;

  key_event_gen_if rpt_if ();

  key_event_gen #(
    .FIFO_DEPTH    (DEPTH),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_PERIOD (PERIOD)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .rpt       (rpt_if),
    .keycode   (keycode),
    .key_valid (key_valid),
    .overflow  (overflow)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0] rpt_slots [6];

  // Reference model state
  int         m_q[$];
  logic [7:0] m_prev [6];
  logic [7:0] m_held;
  int         m_rep;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 6; i++) m_prev[i] = 8'h00;
    m_held = 8'h00;
    m_rep  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] k);
    if (m_q.size() < DEPTH) m_q.push_back(int'(k));
    else m_ovf = 1'b1;
  endtask

  task automatic set_slots(input logic [7:0] a, b, c, d, e, f);
    rpt_slots[0] = a; rpt_slots[1] = b; rpt_slots[2] = c;
    rpt_slots[3] = d; rpt_slots[4] = e; rpt_slots[5] = f;
  endtask

  function automatic bit is_rollover();
    for (int i = 0; i < 6; i++) if (rpt_slots[i] != 8'h01) return 1'b0;
    return 1'b1;
  endfunction

  // New presses are keys absent from the previous report; the last one becomes held.
  task automatic model_report();
    logic [7:0] last;
    logic [7:0] nh;
    bit         seen;
    bit         present;
    if (is_rollover()) return;
    last = 8'h00;
    for (int i = 0; i < 6; i++) begin
      seen = 1'b0;
      for (int j = 0; j < 6; j++) if (m_prev[j] == rpt_slots[i]) seen = 1'b1;
      if (rpt_slots[i] != 8'h00 && !seen) begin
        model_push(rpt_slots[i]);
        last = rpt_slots[i];
      end
    end
    present = 1'b0;
    for (int i = 0; i < 6; i++) if (rpt_slots[i] == m_held) present = 1'b1;
    if (last != 8'h00) nh = last;
    else nh = present ? m_held : 8'h00;
    if (nh != m_held) begin
      m_held = nh;
      m_rep  = 0;
    end
    for (int i = 0; i < 6; i++) m_prev[i] = rpt_slots[i];
  endtask

  task automatic send_report();
    logic [7:0] bytes [8];
    int guard;
    int busy;
    bytes[0] = 8'($urandom);
    bytes[1] = 8'($urandom);
    for (int i = 0; i < 6; i++) bytes[i+2] = rpt_slots[i];
    $display("report %02h %02h %02h %02h %02h %02h", rpt_slots[0], rpt_slots[1],
             rpt_slots[2], rpt_slots[3], rpt_slots[4], rpt_slots[5]);
    for (int i = 0; i < 8; i++) begin
      rpt_if.rpt_data  = bytes[i];
      rpt_if.rpt_valid = 1'b1;
      guard = 0;
      @(negedge Clk);
      while (!rpt_if.rpt_ready && guard < 50) begin
        @(negedge Clk);
        guard++;
      end
      if (guard >= 50) begin
        check_cnt++;
        $error("FAIL hs_timeout: observed=ready_low expected=ready_high byte=%0d", i);
      end
      @(posedge Clk);
      #1;
    end
    rpt_if.rpt_valid = 1'b0;
    busy = 0;
    @(negedge Clk);
    while (!rpt_if.rpt_ready && busy < 40) begin
      busy++;
      @(negedge Clk);
    end
    check("busy_cycles", 32'(busy), is_rollover() ? 32'd1 : 32'd8);
    model_report();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    logic [7:0] ek;
    logic       ev;
    frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    if (m_q.size() > 0) begin
      ek = 8'(m_q.pop_front());
      ev = 1'b1;
    end else begin
      ek = 8'h00;
      ev = 1'b0;
    end
    if (m_held != 8'h00) begin
      m_rep++;
      if (m_rep == DELAY) begin
        model_push(m_held);
        m_rep = DELAY - PERIOD;
      end
    end
    $display("frame keycode=%02h key_valid=%0b overflow=%0b", keycode, key_valid, overflow);
    check("keycode", 32'(keycode), 32'(ek));
    check("key_valid", 32'(key_valid), 32'(ev));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    Reset            = 1'b1;
    frame_clk        = 1'b0;
    rpt_if.rpt_valid = 1'b0;
    rpt_if.rpt_data  = 8'h00;
    model_reset();
    repeat (5) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_keycode", 32'(keycode), 32'h00);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_rpt_ready", 32'(rpt_if.rpt_ready), 32'h1);

    // Single press shows for exactly one frame
    set_slots(8'h00, 8'h00, 8'h52, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();
    frame();
    set_slots(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();

    // Two presses in slot order, then an identical report adds nothing
    set_slots(8'h51, 8'h58, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();
    frame();
    send_report();
    frame();
    set_slots(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();

    // Auto-repeat over a long hold
    set_slots(8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    for (int f = 0; f <= 42; f++) frame();
    set_slots(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();

    // Rollover report must leave the previous key set untouched
    set_slots(8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();
    set_slots(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    send_report();
    frame();
    set_slots(8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();
    set_slots(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();

    // Five new keys into a four-entry queue
    set_slots(8'h51, 8'h52, 8'h58, 8'h04, 8'h05, 8'h00);
    send_report();
    check("ovf_after_burst", 32'(overflow), 32'(m_ovf));
    for (int f = 0; f < 5; f++) frame();
    set_slots(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();

    // Randomized reports interleaved with frames
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_slots(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
      end else begin
        for (int i = 0; i < 6; i++)
          rpt_slots[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h04 + $urandom_range(0, 5));
      end
      send_report();
      repeat ($urandom_range(1, 3)) frame();
    end

    // Reset in the middle of a report
    for (int i = 0; i < 3; i++) begin
      rpt_if.rpt_data  = 8'h58;
      rpt_if.rpt_valid = 1'b1;
      @(posedge Clk);
      #1;
    end
    rpt_if.rpt_valid = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    check("midrst_overflow", 32'(overflow), 32'h0);
    check("midrst_key_valid", 32'(key_valid), 32'h0);
    set_slots(8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report();
    frame();
    frame();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
